// File: rtl/prog_mem_pkg.sv
// Shared constants for the program memory loader: opcode encodings,
// opcode field width and the loader FSM state encoding.
package prog_mem_pkg;

    localparam int OPC_SIZE = 5;

    localparam logic [4:0] HLT  = 5'd0;
    localparam logic [4:0] STO  = 5'd1;
    localparam logic [4:0] LD_  = 5'd2;
    localparam logic [4:0] LDI  = 5'd3;
    localparam logic [4:0] ADD  = 5'd4;
    localparam logic [4:0] ADDI = 5'd5;
    localparam logic [4:0] SUB  = 5'd6;
    localparam logic [4:0] SUBI = 5'd7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Program storage: one write port, one registered read port, no reset.
// The read register only updates on a read enable, so it holds otherwise.
module prog_mem_ram #(
    parameter int AW    = 11,
    parameter int DW    = 16,
    parameter int DEPTH = 2048
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          re_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (re_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prog_mem_ld.sv
// Program memory with a streaming loader: LOAD writes words sequentially until
// an HLT word or the last location; RUN serves single-cycle-latency fetches.
module prog_mem_ld
    import prog_mem_pkg::*;
#(
    parameter int ADDR_BUS  = 11,
    parameter int DATA_SIZE = 16,
    parameter int OPC_SIZE  = prog_mem_pkg::OPC_SIZE,
    parameter int DEPTH     = 2**ADDR_BUS
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Load_Start,
    input  logic                 Load_Valid,
    input  logic [DATA_SIZE-1:0] Load_Data,
    output logic                 Load_Ready,
    output logic                 Load_Done,
    output logic [ADDR_BUS:0]    Load_Count,
    output logic                 Busy,
    input  logic                 Fetch_En,
    input  logic [ADDR_BUS-1:0]  Addr,
    output logic [DATA_SIZE-1:0] Data,
    output logic                 Data_Valid
);

    localparam int                IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);
    localparam logic [ADDR_BUS:0]   DEPTH_W   = (ADDR_BUS + 1)'(DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_BUS-1:0]   ptr_q, ptr_d;
    logic [ADDR_BUS:0]     cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  dv_q, dv_d;
    logic                  zero_q, zero_d;
    logic                  wr_en, rd_en, last_word, addr_ok;
    logic [OPC_SIZE-1:0]   opc;
    logic [DATA_SIZE-1:0]  rd_data;

    assign opc     = Load_Data[DATA_SIZE-1 -: OPC_SIZE];
    assign addr_ok = {1'b0, Addr} < DEPTH_W;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        dv_d      = 1'b0;
        zero_d    = zero_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        last_word = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Fetch_En) begin
                    dv_d   = 1'b1;
                    rd_en  = addr_ok;
                    zero_d = !addr_ok;
                end
                if (Load_Start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (Load_Valid) begin
                    wr_en     = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    last_word = (opc == OPC_SIZE'(HLT)) || (ptr_q == LAST_ADDR);
                    if (last_word) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
            zero_q  <= zero_d;
        end
    end

    // The RAM read register has no reset; zero_q masks it after reset and
    // for out-of-range fetches so Data reads as an HLT word.
    prog_mem_ram #(
        .AW    (IW),
        .DW    (DATA_SIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (Clk),
        .we_i      (wr_en),
        .wr_addr_i (ptr_q[IW-1:0]),
        .wr_data_i (Load_Data),
        .re_i      (rd_en),
        .rd_addr_i (Addr[IW-1:0]),
        .rd_data_o (rd_data)
    );

    assign Load_Ready = (state_q == ST_LOAD);
    assign Busy       = (state_q == ST_LOAD);
    assign Load_Done  = done_q;
    assign Load_Count = cnt_q;
    assign Data_Valid = dv_q;
    assign Data       = zero_q ? '0 : rd_data;

endmodule

// File: tb/tb_prog_mem_ld.sv
// Bench for prog_mem_ld: a default-size instance and a DEPTH=8 instance,
// random programs checked against a plain array model of program memory.
module tb_prog_mem_ld;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ls [2];
    logic        lv [2];
    logic        fe [2];
    logic [15:0] ld [2];
    logic [10:0] addr [2];
    logic        rdy [2];
    logic        done [2];
    logic        busy [2];
    logic        dv [2];
    logic [15:0] dat [2];
    logic [11:0] cnt_b;
    logic [4:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [2][2048];
    int          dep [2];
    logic [15:0] exp_data [2];
    logic [15:0] prog [$];
    int          fq [$];

    prog_mem_ld u_big (
        .Clk(clk), .Reset(rst_n),
        .Load_Start(ls[0]), .Load_Valid(lv[0]), .Load_Data(ld[0]),
        .Load_Ready(rdy[0]), .Load_Done(done[0]), .Load_Count(cnt_b), .Busy(busy[0]),
        .Fetch_En(fe[0]), .Addr(addr[0]), .Data(dat[0]), .Data_Valid(dv[0])
    );

    prog_mem_ld #(.ADDR_BUS(4), .DEPTH(8)) u_small (
        .Clk(clk), .Reset(rst_n),
        .Load_Start(ls[1]), .Load_Valid(lv[1]), .Load_Data(ld[1]),
        .Load_Ready(rdy[1]), .Load_Done(done[1]), .Load_Count(cnt_s), .Busy(busy[1]),
        .Fetch_En(fe[1]), .Addr(addr[1][3:0]), .Data(dat[1]), .Data_Valid(dv[1])
    );

    function automatic logic [11:0] cnt_of(int s);
        return (s == 1) ? {7'b0, cnt_s} : cnt_b;
    endfunction

    function automatic logic [15:0] ref_word(int s, int a);
        return (a >= dep[s]) ? 16'h0000 : model[s][a];
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [4:0]  o;
        logic [10:0] r;
        o = 5'($urandom_range(1, 31));
        r = 11'($urandom);
        return {o, r};
    endfunction

    function automatic logic [15:0] rnd_hlt();
        logic [10:0] r;
        r = 11'($urandom);
        return {5'b0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_prog(int len, bit term);
        prog.delete();
        for (int i = 0; i < len - 1; i++) prog.push_back(rnd_op());
        prog.push_back(term ? rnd_hlt() : rnd_op());
    endtask

    // Stream the global program; the bench decides where the load must end.
    task automatic do_load(int s, bit gaps, bit poke, bit skip_start);
        int n;
        n = prog.size();
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i][15:11] == 5'd0 || i == dep[s] - 1) begin
                n = i + 1;
                break;
            end
        end
        if (!skip_start) begin
            ls[s] = 1'b1;
            step();
            ls[s] = 1'b0;
        end
        checks++;
        if (busy[s] !== 1'b1 || rdy[s] !== 1'b1 || cnt_of(s) !== 12'd0) begin
            errors++;
            $display("FAIL load_enter s=%0d busy=%b ready=%b count=%0d (exp 1 1 0)", s, busy[s], rdy[s], cnt_of(s));
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                lv[s] = 1'b0;
                ld[s] = rnd_op();
                if (poke) begin
                    ls[s] = 1'b1;
                    fe[s] = 1'b1;
                    addr[s] = 11'($urandom_range(0, 15));
                end
                step();
                ls[s] = 1'b0;
                fe[s] = 1'b0;
                checks++;
                if (busy[s] !== 1'b1 || cnt_of(s) !== 12'(i) || dv[s] !== 1'b0 || dat[s] !== exp_data[s]) begin
                    errors++;
                    $display("FAIL load_gap s=%0d i=%0d busy=%b count=%0d dv=%b data=%h (exp 1 %0d 0 %h)",
                             s, i, busy[s], cnt_of(s), dv[s], dat[s], i, exp_data[s]);
                end
            end
            lv[s] = 1'b1;
            ld[s] = prog[i];
            step();
            lv[s] = 1'b0;
            model[s][i] = prog[i];
            checks++;
            if (i == n - 1) begin
                if (done[s] !== 1'b1 || busy[s] !== 1'b0 || rdy[s] !== 1'b0 || cnt_of(s) !== 12'(n)) begin
                    errors++;
                    $display("FAIL load_exit s=%0d done=%b busy=%b ready=%b count=%0d (exp 1 0 0 %0d)",
                             s, done[s], busy[s], rdy[s], cnt_of(s), n);
                end
            end else begin
                if (done[s] !== 1'b0 || busy[s] !== 1'b1 || cnt_of(s) !== 12'(i + 1)) begin
                    errors++;
                    $display("FAIL load_word s=%0d i=%0d done=%b busy=%b count=%0d (exp 0 1 %0d)",
                             s, i, done[s], busy[s], cnt_of(s), i + 1);
                end
            end
        end
        step();
        checks++;
        if (done[s] !== 1'b0 || busy[s] !== 1'b0 || cnt_of(s) !== 12'(n)) begin
            errors++;
            $display("FAIL load_after s=%0d done=%b busy=%b count=%0d (exp 0 0 %0d)", s, done[s], busy[s], cnt_of(s), n);
        end
    endtask

    task automatic fetch_burst(int s);
        fe[s] = 1'b1;
        for (int i = 0; i < fq.size(); i++) begin
            addr[s] = 11'(fq[i]);
            step();
            exp_data[s] = ref_word(s, fq[i]);
            checks++;
            if (dv[s] !== 1'b1 || dat[s] !== exp_data[s]) begin
                errors++;
                $display("FAIL fetch s=%0d addr=%0d dv=%b data=%h (exp 1 %h)", s, fq[i], dv[s], dat[s], exp_data[s]);
            end
        end
        fe[s] = 1'b0;
        addr[s] = 11'($urandom_range(0, 15));
        step();
        checks++;
        if (dv[s] !== 1'b0 || dat[s] !== exp_data[s]) begin
            errors++;
            $display("FAIL fetch_hold s=%0d dv=%b data=%h (exp 0 %h)", s, dv[s], dat[s], exp_data[s]);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (busy[s] !== 1'b0 || rdy[s] !== 1'b0 || done[s] !== 1'b0 || dv[s] !== 1'b0 ||
                dat[s] !== 16'h0 || cnt_of(s) !== 12'd0) begin
                errors++;
                $display("FAIL %s s=%0d busy=%b ready=%b done=%b dv=%b data=%h count=%0d (exp all 0)",
                         tag, s, busy[s], rdy[s], done[s], dv[s], dat[s], cnt_of(s));
            end
            exp_data[s] = 16'h0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fq.delete();
        fq.push_back(0);
        fetch_burst(0);
    endtask

    task automatic test_spec_program();
        prog.delete();
        prog = '{16'h1810, 16'h0801, 16'h1001, 16'h28FF, 16'h0802, 16'h1010, 16'h0000};
        do_load(0, 1'b0, 1'b0, 1'b0);
        fq.delete();
        for (int a = 0; a < 7; a++) fq.push_back(a);
        fetch_burst(0);
    endtask

    task automatic test_reset_mid_load();
        make_prog(7, 1'b1);
        ls[0] = 1'b1;
        step();
        ls[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lv[0] = 1'b1;
            ld[0] = prog[i];
            step();
            model[0][i] = prog[i];
        end
        lv[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fq.delete();
        for (int a = 0; a < 4; a++) fq.push_back(a);
        fetch_burst(0);
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 3; k++) begin
            make_prog($urandom_range(3, 12), 1'b1);
            do_load(0, 1'b1, 1'b1, 1'b0);
            fq.delete();
            for (int a = 0; a < 14; a++) fq.push_back(a);
            fetch_burst(0);
        end
    endtask

    task automatic test_fetch_then_load();
        fe[0] = 1'b1;
        ls[0] = 1'b1;
        addr[0] = 11'd3;
        step();
        fe[0] = 1'b0;
        ls[0] = 1'b0;
        exp_data[0] = ref_word(0, 3);
        checks++;
        if (dv[0] !== 1'b1 || dat[0] !== exp_data[0] || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_and_start dv=%b data=%h busy=%b (exp 1 %h 1)", dv[0], dat[0], busy[0], exp_data[0]);
        end
        make_prog(4, 1'b1);
        do_load(0, 1'b0, 1'b0, 1'b1);
        fq.delete();
        for (int a = 0; a < 5; a++) fq.push_back(a);
        fetch_burst(0);
    endtask

    task automatic test_depth();
        make_prog(10, 1'b0);
        do_load(1, 1'b0, 1'b0, 1'b0);
        fq.delete();
        for (int a = 0; a < 10; a++) fq.push_back(a);
        fq.push_back(15);
        fetch_burst(1);
        make_prog(10, 1'b0);
        do_load(1, 1'b1, 1'b1, 1'b0);
        fq.delete();
        for (int a = 7; a < 10; a++) fq.push_back(a);
        fetch_burst(1);
    endtask

    task automatic test_back_to_back();
        fq.delete();
        for (int i = 0; i < 40; i++) begin
            fq.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 15)));
        end
        fetch_burst(0);
        fq.delete();
        for (int i = 0; i < 30; i++) fq.push_back(int'($urandom_range(0, 15)));
        fetch_burst(1);
    endtask

    initial begin
        dep[0] = 2048;
        dep[1] = 8;
        for (int s = 0; s < 2; s++) begin
            ls[s] = 1'b0;
            lv[s] = 1'b0;
            fe[s] = 1'b0;
            ld[s] = 16'h0;
            addr[s] = 11'h0;
            exp_data[s] = 16'h0;
            for (int a = 0; a < 2048; a++) model[s][a] = 16'h0;
        end
        test_reset();
        test_spec_program();
        test_reset_mid_load();
        test_gaps();
        test_fetch_then_load();
        test_depth();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
